beep_seq: RTL



---
 rtl/beep_seq_pkg.sv | 25 ++
 rtl/beep_seq_if.sv | 28 ++
 rtl/beep_seq_note_fifo.sv | 67 ++++++
 rtl/beep_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/beep_seq_pkg.sv
// Shared definitions for the melody sequencer: FSM state encoding and the
// field layout of the 16-bit {duration, note} word pushed by the CPU.
package beep_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_t;

  localparam int unsigned NOTE_LSB = 0;
  localparam int unsigned NOTE_W   = 8;
  localparam int unsigned DUR_LSB  = 8;
  localparam int unsigned DUR_W    = 8;

  function automatic logic [NOTE_W-1:0] note_of(input logic [15:0] word);
    return word[NOTE_LSB +: NOTE_W];
  endfunction

  function automatic logic [DUR_W-1:0] dur_of(input logic [15:0] word);
    return word[DUR_LSB +: DUR_W];
  endfunction

endpackage

// File: rtl/beep_seq_if.sv
// CPU-side bus of the melody sequencer.
//   push/din/abort : write strobe, {duration, note} word, flush request (CPU -> sequencer)
//   mode           : tone select for the buzzer generator
//   busy/full/empty/level/overflow/done : status for CPU polling
interface beep_seq_if #(
  parameter int unsigned DEPTH = 16
);
  logic                     push;
  logic [15:0]              din;
  logic                     abort;
  logic [7:0]               mode;
  logic                     busy;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;
  logic                     done;

  modport master (
    output push, din, abort,
    input  mode, busy, full, empty, level, overflow, done
  );

  modport slave (
    input  push, din, abort,
    output mode, busy, full, empty, level, overflow, done
  );
endinterface

// File: rtl/beep_seq_note_fifo.sv
// note_fifo: synchronous DEPTH x W FIFO holding queued {duration, note} words.
//   clk, reset_ : clock, synchronous active-low reset
//   push, din   : write strobe and data (dropped while full or flushing)
//   pop         : read strobe; head word appears on dout after the edge
//   flush       : empties the FIFO, overrides push and pop
//   dout        : registered head word
//   full, empty, level : occupancy status
module note_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 16
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

  assign wr_en = push & ~full & ~flush;
  assign rd_en = pop & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/beep_seq.sv
// beep_seq: melody sequencer driving the buzzer tone generator's mode input.
// The CPU queues {duration, note} words; each is played for duration*TICK_DIV
// clocks followed by a GAP_TICKS*TICK_DIV silent gap.
//   clk, reset_ : clock, synchronous active-low reset
//   bus         : beep_seq_if slave (push/din/abort in; mode and status out)
module beep_seq
  import beep_seq_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TICK_DIV  = 625000,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset_,
  beep_seq_if.slave  bus
);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  state_t        state, state_n;
  logic [7:0]    mode_q, mode_n;
  logic [7:0]    rem_q, rem_n;
  logic [PW-1:0] presc_q, presc_n;
  logic          done_q, done_n;
  logic          ovf_q;
  logic          pop;
  logic          tick;

  logic [15:0]   head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;

  note_fifo #(
    .DEPTH (DEPTH),
    .W     (16)
  ) u_fifo (
    .clk    (clk),
    .reset_ (reset_),
    .push   (bus.push),
    .din    (bus.din),
    .pop    (pop),
    .flush  (bus.abort),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    rem_n   = rem_q;
    presc_n = presc_q;
    done_n  = 1'b0;
    pop     = 1'b0;

    case (state)
      S_IDLE: begin
        mode_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        presc_n = '0;
        if (dur_of(head) == '0) begin
          state_n = S_IDLE;
        end else begin
          mode_n  = note_of(head);
          rem_n   = dur_of(head);
          state_n = S_PLAY;
        end
      end
      // PLAY and GAP share the tick countdown; only the exit target differs.
      S_PLAY, S_GAP: begin
        if (tick) begin
          presc_n = '0;
          if (rem_q == 8'd1) begin
            mode_n = '0;
            if (state == S_PLAY && GAP_TICKS != 0) begin
              rem_n   = 8'(GAP_TICKS);
              state_n = S_GAP;
            end else begin
              rem_n   = '0;
              state_n = S_IDLE;
              done_n  = fifo_empty;
            end
          end else begin
            rem_n = rem_q - 8'd1;
          end
        end else begin
          presc_n = presc_q + PW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (bus.abort) begin
      state_n = S_IDLE;
      mode_n  = '0;
      rem_n   = '0;
      presc_n = '0;
      done_n  = 1'b0;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state   <= S_IDLE;
      mode_q  <= '0;
      rem_q   <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      mode_q  <= mode_n;
      rem_q   <= rem_n;
      presc_q <= presc_n;
      done_q  <= done_n;
    end
  end

  // A push against a full FIFO is lost even if a pop frees a slot that cycle.
  always_ff @(posedge clk) begin
    if (!reset_)                       ovf_q <= 1'b0;
    else if (bus.abort)                ovf_q <= 1'b0;
    else if (bus.push && fifo_full)    ovf_q <= 1'b1;
  end

  assign bus.mode     = mode_q;
  assign bus.busy     = (state != S_IDLE) | ~fifo_empty;
  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.level    = fifo_level;
  assign bus.overflow = ovf_q;
  assign bus.done     = done_q;
endmodule
